// File: rtl/instr_fetch_rom_if.sv
// rtl/instr_fetch_rom_if.sv - load bus and instruction stream between fetch store and its neighbours
interface instr_fetch_rom_if #(
    parameter int INSTR_W = 9,
    parameter int PC_W    = 16,
    parameter int PSEL_W  = 2
);
    logic                load_en;
    logic [PSEL_W-1:0]   load_prog;
    logic [PC_W-1:0]     load_addr;
    logic [INSTR_W-1:0]  load_data;

    logic                out_valid;
    logic                out_ready;
    logic [PC_W-1:0]     pc_out;
    logic                format;
    logic [3:0]          opcode;
    logic                sign;
    logic [INSTR_W-7:0]  operand;
    logic [INSTR_W-2:0]  immediate;

    modport master (
        output load_en, load_prog, load_addr, load_data, out_ready,
        input  out_valid, pc_out, format, opcode, sign, operand, immediate
    );

    modport slave (
        input  load_en, load_prog, load_addr, load_data, out_ready,
        output out_valid, pc_out, format, opcode, sign, operand, immediate
    );
endinterface

// File: rtl/instr_fetch_rom.sv
// rtl/instr_fetch_rom.sv - writable multi-bank instruction store with registered fetch and valid/ready output
module instr_fetch_rom #(
    parameter int                   INSTR_W   = 9,
    parameter int                   DEPTH     = 128,
    parameter int                   PC_W      = 16,
    parameter int                   NUM_PROGS = 4,
    parameter int                   PSEL_W    = 2,
    parameter logic [INSTR_W-1:0]   HALT_WORD = 9'b110110000
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_rom_if.slave    bus,
    input  logic [PSEL_W-1:0]   prog_sel_i,
    input  logic                start_i,
    input  logic                redirect_en_i,
    input  logic [PC_W-1:0]     redirect_pc_i,
    output logic                busy_o,
    output logic                halted_o,
    output logic                fault_o
);
    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              IW       = PSEL_W + AW;
    localparam logic [PC_W-1:0] DEPTH_PC = PC_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FAULT} state_e;

    state_e              state_q;
    logic [PSEL_W-1:0]   bank_q;
    logic [PC_W-1:0]     fetch_pc_q;
    logic [PC_W-1:0]     pc_out_q;
    logic [INSTR_W-1:0]  word_q;
    logic                valid_q;

    // Banks are laid out back to back; a bank occupies 2**AW slots so the index is a plain concat.
    logic [INSTR_W-1:0]  mem_q [0:(1<<IW)-1];

    logic [PSEL_W-1:0]   rd_bank;
    logic [PC_W-1:0]     rd_pc;
    logic [PC_W-1:0]     rd_pc_inc;
    logic [INSTR_W-1:0]  rd_word;
    logic                rd_oob;
    logic                halt_held;
    logic                load_ok;

    always_comb begin
        rd_bank = bank_q;
        rd_pc   = fetch_pc_q;
        if (start_i) begin
            rd_bank = prog_sel_i;
            rd_pc   = '0;
        end else if (redirect_en_i) begin
            rd_pc   = redirect_pc_i;
        end
    end

    assign rd_pc_inc = rd_pc + PC_W'(1);
    assign rd_word   = mem_q[{rd_bank, rd_pc[AW-1:0]}];
    assign rd_oob    = (rd_pc >= DEPTH_PC);
    assign halt_held = valid_q && (word_q == HALT_WORD);
    assign load_ok   = bus.load_en && (state_q != S_RUN) && (bus.load_addr < DEPTH_PC);

    // No reset here: program contents survive rst_n.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem_q[{bus.load_prog, bus.load_addr[AW-1:0]}] <= bus.load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bank_q     <= '0;
            fetch_pc_q <= '0;
            pc_out_q   <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
        end else if (start_i) begin
            state_q    <= S_RUN;
            bank_q     <= prog_sel_i;
            word_q     <= rd_word;
            pc_out_q   <= '0;
            fetch_pc_q <= rd_pc_inc;
            valid_q    <= 1'b1;
        end else if (state_q == S_RUN) begin
            // A redirect discards the held word, even an unaccepted halt.
            if (redirect_en_i || (!halt_held && (!valid_q || bus.out_ready))) begin
                if (rd_oob) begin
                    state_q <= S_FAULT;
                    valid_q <= 1'b0;
                end else begin
                    word_q     <= rd_word;
                    pc_out_q   <= rd_pc;
                    fetch_pc_q <= rd_pc_inc;
                    valid_q    <= 1'b1;
                end
            end else if (halt_held && bus.out_ready) begin
                state_q <= S_DONE;
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.pc_out    = pc_out_q;
    assign bus.format    = word_q[INSTR_W-1];
    assign bus.opcode    = word_q[INSTR_W-2:INSTR_W-5];
    assign bus.sign      = word_q[INSTR_W-6];
    assign bus.operand   = word_q[INSTR_W-7:0];
    assign bus.immediate = word_q[INSTR_W-2:0];

    assign busy_o   = (state_q == S_RUN);
    assign halted_o = (state_q == S_DONE);
    assign fault_o  = (state_q == S_FAULT);
endmodule

// File: tb/tb_instr_fetch_rom.sv
// tb/tb_instr_fetch_rom.sv - vector-table and directed-sequence checks for instr_fetch_rom
module tb_instr_fetch_rom;
    localparam logic [8:0] HALT = 9'b110110000;
    localparam logic [2:0] ST_B = 3'b001;
    localparam logic [2:0] ST_H = 3'b010;
    localparam logic [2:0] ST_F = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  prog_sel = '0;
    logic        start = 1'b0;
    logic        redirect_en = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        busy, halted, fault;

    int total = 0;
    int bad = 0;

    instr_fetch_rom_if #(.INSTR_W(9), .PC_W(16), .PSEL_W(2)) bus ();

    instr_fetch_rom dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .prog_sel_i    (prog_sel),
        .start_i       (start),
        .redirect_en_i (redirect_en),
        .redirect_pc_i (redirect_pc),
        .busy_o        (busy),
        .halted_o      (halted),
        .fault_o       (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [1:0]  ps;
        logic        re;
        logic [15:0] rpc;
        logic        rdy;
        logic        ev;
        logic [15:0] epc;
        logic [8:0]  ew;
        logic [2:0]  ests;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic st, input logic [1:0] ps, input logic re, input logic [15:0] rpc,
                       input logic rdy, input logic ev, input logic [15:0] epc, input logic [8:0] ew,
                       input logic [2:0] ests);
        vec_t v;
        v.st = st; v.ps = ps; v.re = re; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.ew = ew; v.ests = ests;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [15:0] epc,
                           input logic [8:0] ew, input logic [2:0] ests);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(ev));
        chk({tag, ".pc"}, 32'(bus.pc_out), 32'(epc));
        chk({tag, ".fields"}, 32'({bus.format, bus.opcode, bus.sign, bus.operand}), 32'(ew));
        chk({tag, ".imm"}, 32'(bus.immediate), 32'(ew[7:0]));
        chk({tag, ".status"}, 32'({fault, halted, busy}), 32'(ests));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] prog, input logic [15:0] addr, input logic [8:0] data);
        bus.load_en   = 1'b1;
        bus.load_prog = prog;
        bus.load_addr = addr;
        bus.load_data = data;
        tick();
        bus.load_en   = 1'b0;
    endtask

    initial begin
        bus.load_en   = 1'b0;
        bus.load_prog = '0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.out_ready = 1'b0;

        tick();
        tick();
        chk_out("reset", 1'b0, 16'd0, 9'h000, 3'b000);
        rst_n = 1'b1;
        tick();

        load(2'd1, 16'd0, 9'h000);
        load(2'd1, 16'd1, 9'h178);
        load(2'd1, 16'd2, 9'h080);
        load(2'd1, 16'd3, HALT);
        for (int i = 0; i < 15; i++) begin
            load(2'd2, 16'(i), (i == 12) ? HALT : 9'(9'h020 + i));
        end
        load(2'd3, 16'd0, 9'h001);
        load(2'd3, 16'd127, 9'h005);
        chk_out("idle", 1'b0, 16'd0, 9'h000, 3'b000);

        // bank 1 straight run with a 3-cycle stall at pc 2
        add(1, 1, 0, 0,   1, 1, 0,   9'h000, ST_B);
        add(0, 0, 0, 0,   1, 1, 1,   9'h178, ST_B);
        add(0, 0, 0, 0,   1, 1, 2,   9'h080, ST_B);
        add(0, 0, 0, 0,   0, 1, 2,   9'h080, ST_B);
        add(0, 0, 0, 0,   0, 1, 2,   9'h080, ST_B);
        add(0, 0, 0, 0,   0, 1, 2,   9'h080, ST_B);
        add(0, 0, 0, 0,   1, 1, 3,   HALT,   ST_B);
        add(0, 0, 0, 0,   1, 0, 3,   HALT,   ST_H);
        add(0, 0, 0, 0,   1, 0, 3,   HALT,   ST_H);
        // bank 2: redirect over an unaccepted word, redirect with accept, out-of-range redirect
        add(1, 2, 0, 0,   0, 1, 0,   9'h020, ST_B);
        add(0, 0, 0, 0,   0, 1, 0,   9'h020, ST_B);
        add(0, 0, 0, 0,   1, 1, 1,   9'h021, ST_B);
        add(0, 0, 0, 0,   1, 1, 2,   9'h022, ST_B);
        add(0, 0, 0, 0,   1, 1, 3,   9'h023, ST_B);
        add(0, 0, 0, 0,   1, 1, 4,   9'h024, ST_B);
        add(0, 0, 1, 10,  0, 1, 10,  9'h02A, ST_B);
        add(0, 0, 0, 0,   1, 1, 11,  9'h02B, ST_B);
        add(0, 0, 1, 2,   1, 1, 2,   9'h022, ST_B);
        add(0, 0, 0, 0,   1, 1, 3,   9'h023, ST_B);
        add(0, 0, 1, 128, 1, 0, 3,   9'h023, ST_F);
        add(0, 0, 0, 0,   1, 0, 3,   9'h023, ST_F);
        add(1, 2, 0, 0,   1, 1, 0,   9'h020, ST_B);
        add(0, 0, 1, 11,  1, 1, 11,  9'h02B, ST_B);
        add(0, 0, 0, 0,   1, 1, 12,  HALT,   ST_B);
        add(0, 0, 0, 0,   0, 1, 12,  HALT,   ST_B);
        add(0, 0, 0, 0,   1, 0, 12,  HALT,   ST_H);
        // bank 3: run off the end of the bank
        add(1, 3, 0, 0,   1, 1, 0,   9'h001, ST_B);
        add(0, 0, 1, 127, 1, 1, 127, 9'h005, ST_B);
        add(0, 0, 0, 0,   1, 0, 127, 9'h005, ST_F);
        // start beats redirect
        add(1, 1, 1, 10,  1, 1, 0,   9'h000, ST_B);
        add(0, 0, 0, 0,   1, 1, 1,   9'h178, ST_B);

        for (int i = 0; i < vq.size(); i++) begin
            start       = vq[i].st;
            prog_sel    = vq[i].ps;
            redirect_en = vq[i].re;
            redirect_pc = vq[i].rpc;
            bus.out_ready = vq[i].rdy;
            tick();
            chk_out($sformatf("vec%0d", i), vq[i].ev, vq[i].epc, vq[i].ew, vq[i].ests);
        end
        start = 1'b0;
        redirect_en = 1'b0;

        // load during RUN must be ignored
        start = 1'b1; prog_sel = 2'd1; bus.out_ready = 1'b0;
        tick();
        start = 1'b0;
        chk_out("runload.start", 1'b1, 16'd0, 9'h000, ST_B);
        load(2'd1, 16'd1, 9'h0FF);
        chk_out("runload.hold", 1'b1, 16'd0, 9'h000, ST_B);
        bus.out_ready = 1'b1;
        tick();
        chk_out("runload.word1", 1'b1, 16'd1, 9'h178, ST_B);

        // asynchronous reset mid-run, then replay
        #2 rst_n = 1'b0;
        #1;
        chk_out("midreset", 1'b0, 16'd0, 9'h000, 3'b000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk_out("postreset", 1'b0, 16'd0, 9'h000, 3'b000);
        start = 1'b1; prog_sel = 2'd1;
        tick();
        start = 1'b0;
        chk_out("replay0", 1'b1, 16'd0, 9'h000, ST_B);
        tick();
        chk_out("replay1", 1'b1, 16'd1, 9'h178, ST_B);
        tick();
        chk_out("replay2", 1'b1, 16'd2, 9'h080, ST_B);
        tick();
        chk_out("replay3", 1'b1, 16'd3, HALT, ST_B);
        tick();
        chk_out("replay_done", 1'b0, 16'd3, HALT, ST_H);

        // load alongside start: fetch sees old word, the write lands; an out-of-range write is dropped
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        load(2'd0, 16'd0, 9'h011);
        load(2'd0, 16'd128, 9'h0AA);
        bus.load_en = 1'b1; bus.load_prog = 2'd0; bus.load_addr = 16'd0; bus.load_data = 9'h033;
        start = 1'b1; prog_sel = 2'd0;
        tick();
        bus.load_en = 1'b0;
        chk_out("ldstart.old", 1'b1, 16'd0, 9'h011, ST_B);
        tick();
        start = 1'b0;
        chk_out("ldstart.new", 1'b1, 16'd0, 9'h033, ST_B);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
